uart_rx_packer: RTL

UART_RX_PACKER -- requirements
Module: uart_rx_packer

---
 rtl/uart_rx_packer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_packer.sv
// UART receiver that assembles NUM_BYTES consecutive good bytes into one word
// (first byte in the least significant position) and presents it on a
// valid/ready output. Framing, parity and overrun problems are reported as
// single-cycle pulses; a byte only counts once its stop bit is good.
module uart_rx_packer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 12,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                   CLK_I,
    input  logic                   RSTL_I,
    input  logic                   UART_RX_I,
    input  logic                   RX_READY_I,
    output logic                   RX_VALID_O,
    output logic [8*NUM_BYTES-1:0] RX_DATA_O,
    output logic                   FRAME_ERR_O,
    output logic                   PARITY_ERR_O,
    output logic                   OVERRUN_O
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WW = 8 * NUM_BYTES;

    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_e;

    logic          rx_meta_q, rx_sync_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    cur_q, cur_d;
    logic [WW-1:0] word_q, word_d;
    logic          par_fail_q, par_fail_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] data_q, data_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          ovr_q, ovr_d;

    logic          byte_done;
    logic          accept;
    logic [WW-1:0] full_word;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX_I;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            cur_q      <= '0;
            // NOTE: the wide word registers are reset as well, because the output word must read zero during reset.
            word_q     <= '0;
            par_fail_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            cur_q      <= cur_d;
            word_q     <= word_d;
            par_fail_q <= par_fail_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic: frame FSM, byte assembly and output handshake.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        cur_d      = cur_q;
        word_d     = word_q;
        par_fail_d = par_fail_q;
        valid_d    = valid_q;
        data_d     = data_q;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        ovr_d      = 1'b0;
        byte_done  = 1'b0;
        full_word  = word_q;
        accept     = valid_q & RX_READY_I;

        // NOTE: blocking assignments are right here because this block only computes next values; the flops take them with <=.
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d    = DATA;
                        bit_d      = '0;
                        par_fail_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    cur_d = {rx_sync_q, cur_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (((^cur_q) ^ rx_sync_q) != PARITY_ODD) begin
                        perr_d     = 1'b1;
                        par_fail_d = 1'b1;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        // Straight back to IDLE so the next start bit can follow without an idle bit.
                        state_d   = IDLE;
                        byte_done = !par_fail_q;
                    end else begin
                        state_d = WAIT_HIGH;
                        // A frame that already failed parity reports nothing more.
                        if (!par_fail_q) begin
                            ferr_d     = 1'b1;
                            byte_cnt_d = '0;
                            word_d     = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            valid_d = 1'b0;
        end

        if (byte_done) begin
            full_word[{byte_cnt_q, 3'b000} +: 8] = cur_q;
            if (byte_cnt_q == BYTE_LAST) begin
                byte_cnt_d = '0;
                word_d     = '0;
                // A word being accepted this cycle frees the output register for the new one.
                if (!valid_q || accept) begin
                    data_d  = full_word;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                word_d     = full_word;
            end
        end
    end

    assign RX_VALID_O   = valid_q;
    assign RX_DATA_O    = data_q;
    assign FRAME_ERR_O  = ferr_q;
    assign PARITY_ERR_O = perr_q;
    assign OVERRUN_O    = ovr_q;

endmodule
